// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if: requester handshakes and tag-memory macro controls for the arbiter
interface mem_access_arbiter_if;
  logic        wr_req;
  logic [2:0]  wr_bank;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic [2:0]  rd_bank;
  logic [5:0]  rd_addr;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic        acc_err;
  logic        busy;
  logic [15:0] mem_read_in;
  logic [15:0] mem_data_out;
  logic [2:0]  mem_sel;
  logic [5:0]  mem_address;
  logic        PC_B;
  logic        WE;
  logic        SE;
  modport slave (
    input  wr_req, wr_bank, wr_addr, wr_data, rd_req, rd_bank, rd_addr, mem_read_in,
    output wr_ack, rd_ack, rd_data, acc_err, busy, mem_data_out, mem_sel, mem_address, PC_B, WE, SE
  );
  modport master (
    output wr_req, wr_bank, wr_addr, wr_data, rd_req, rd_bank, rd_addr, mem_read_in,
    input  wr_ack, rd_ack, rd_data, acc_err, busy, mem_data_out, mem_sel, mem_address, PC_B, WE, SE
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin sequencer of one writer and one reader onto the tag memory macro
module mem_access_arbiter #(
  parameter int PRE_CYCLES = 1,
  parameter int ACC_CYCLES = 1,
  parameter int REC_CYCLES = 1,
  parameter int DEPTH      = 64
) (
  input  logic                clk,
  input  logic                reset,
  mem_access_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PRE, ACC, CAP, REC} state_t;
  localparam logic [2:0] PRE_N   = 3'(PRE_CYCLES - 1);
  localparam logic [2:0] ACC_N   = 3'(ACC_CYCLES - 1);
  localparam logic [2:0] REC_N   = 3'(REC_CYCLES - 1);
  localparam logic [6:0] DEPTH_W = 7'(DEPTH);
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, bank_q, bank_d, sel_q, sel_d;
  logic [5:0]  addr_q, addr_d, maddr_q, maddr_d;
  logic [15:0] data_q, data_d, mdata_q, mdata_d, rdata_q, rdata_d;
  logic        ptr_q, ptr_d, op_q, op_d, err_q, err_d, gw;
  logic        pc_b_q, pc_b_d, we_q, we_d, se_q, se_d;
  logic        wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d, acc_err_q, acc_err_d, busy_q, busy_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 3'd1;
    ptr_d   = ptr_q;
    op_d    = op_q;
    err_d   = err_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    data_d  = data_q;
    gw      = bus.wr_req & (~bus.rd_req | ~ptr_q);
    case (state_q)
      IDLE: if (bus.wr_req | bus.rd_req) begin
        ptr_d   = gw;
        op_d    = gw;
        bank_d  = gw ? bus.wr_bank : bus.rd_bank;
        addr_d  = gw ? bus.wr_addr : bus.rd_addr;
        data_d  = bus.wr_data;
        err_d   = !$onehot(bank_d) || ({1'b0, addr_d} >= DEPTH_W);
        state_d = err_d ? CAP : PRE;
        cnt_d   = PRE_N;
      end
      PRE: if (cnt_q == 3'd0) begin
        state_d = ACC;
        cnt_d   = ACC_N;
      end
      ACC: state_d = (cnt_q == 3'd0) ? CAP : ACC;
      CAP: begin
        state_d = REC;
        cnt_d   = REC_N;
      end
      REC: state_d = (cnt_q == 3'd0) ? IDLE : REC;
      default: state_d = IDLE;
    endcase
    // outputs are registered, so they are decoded from the state being entered
    pc_b_d    = state_d != PRE;
    we_d      = (state_d == ACC) & op_d;
    se_d      = (state_d == ACC) & ~op_d;
    sel_d     = (state_d inside {PRE, ACC, CAP}) && !err_d ? bank_d : 3'b000;
    maddr_d   = (state_d == PRE) ? addr_d : maddr_q;
    mdata_d   = (state_d == PRE) && op_d ? data_d : mdata_q;
    wr_ack_d  = (state_d == CAP) & op_d;
    rd_ack_d  = (state_d == CAP) & ~op_d;
    acc_err_d = (state_d == CAP) & err_d;
    rdata_d   = (state_d == CAP) && !op_d && !err_d ? bus.mem_read_in : rdata_q;
    busy_d    = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= 1'b0;
      op_q      <= 1'b0;
      err_q     <= 1'b0;
      bank_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      pc_b_q    <= 1'b1;
      we_q      <= 1'b0;
      se_q      <= 1'b0;
      sel_q     <= '0;
      maddr_q   <= '0;
      mdata_q   <= '0;
      rdata_q   <= '0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      acc_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      op_q      <= op_d;
      err_q     <= err_d;
      bank_q    <= bank_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      pc_b_q    <= pc_b_d;
      we_q      <= we_d;
      se_q      <= se_d;
      sel_q     <= sel_d;
      maddr_q   <= maddr_d;
      mdata_q   <= mdata_d;
      rdata_q   <= rdata_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
      acc_err_q <= acc_err_d;
      busy_q    <= busy_d;
    end
  end
  assign bus.PC_B         = pc_b_q;
  assign bus.WE           = we_q;
  assign bus.SE           = se_q;
  assign bus.mem_sel      = sel_q;
  assign bus.mem_address  = maddr_q;
  assign bus.mem_data_out = mdata_q;
  assign bus.rd_data      = rdata_q;
  assign bus.wr_ack       = wr_ack_q;
  assign bus.rd_ack       = rd_ack_q;
  assign bus.acc_err      = acc_err_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: scoreboard bench for default and slow/shallow arbiter instances
module tb_mem_access_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  mem_access_arbiter_if b0();
  mem_access_arbiter_if b1();
  mem_access_arbiter u0 (.clk(clk), .reset(reset), .bus(b0));
  mem_access_arbiter #(.PRE_CYCLES(2), .ACC_CYCLES(3), .REC_CYCLES(1), .DEPTH(32))
    u1 (.clk(clk), .reset(reset), .bus(b1));
  typedef struct {logic wr; logic err; logic [15:0] d;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int checks = 0;
  int errors = 0;
  logic [15:0] m0 [3][64];
  function automatic int bidx(logic [2:0] b);
    return b[2] ? 2 : b[1] ? 1 : 0;
  endfunction
  always @(posedge clk) if (b0.WE) m0[bidx(b0.mem_sel)][b0.mem_address] <= b0.mem_data_out;
  // EPC word 3 is a fixed cell of the macro model
  assign b0.mem_read_in = !b0.SE ? 16'h0 :
    (b0.mem_sel == 3'b001 && b0.mem_address == 6'd3) ? 16'h1234 : m0[bidx(b0.mem_sel)][b0.mem_address];
  assign b1.mem_read_in = 16'h0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle0();
    for (int i = 0; i < 20 && b0.busy; i++) tick();
    chk("idle0", b0.busy, 0);
  endtask
  task automatic idle1();
    for (int i = 0; i < 20 && b1.busy; i++) tick();
    chk("idle1", b1.busy, 0);
  endtask
  always @(negedge clk) if (reset) begin
    chk("u0_we_se", b0.WE & b0.SE, 0);
    chk("u0_acc_pcb", (b0.WE | b0.SE) & ~b0.PC_B, 0);
    chk("u1_acc_pcb", (b1.WE | b1.SE) & ~b1.PC_B, 0);
    if (b0.wr_ack | b0.rd_ack) begin
      if (q0.size() == 0) chk("u0_unexp_ack", q0.size(), 1);
      else begin
        e0 = q0.pop_front();
        chk("u0_ack_wr", b0.wr_ack, e0.wr);
        chk("u0_ack_err", b0.acc_err, e0.err);
        if (!e0.wr) chk("u0_rd_data", b0.rd_data, e0.d);
      end
    end
    if (b1.wr_ack | b1.rd_ack) begin
      if (q1.size() == 0) chk("u1_unexp_ack", q1.size(), 1);
      else begin
        e1 = q1.pop_front();
        chk("u1_ack_wr", b1.wr_ack, e1.wr);
        chk("u1_ack_err", b1.acc_err, e1.err);
      end
    end
  end
  initial begin
    int n, pl, wh, ack_at;
    int c[4];
    c = '{default: 0};
    {b0.wr_req, b0.rd_req, b0.wr_bank, b0.wr_addr, b0.wr_data, b0.rd_bank, b0.rd_addr} = '0;
    {b1.wr_req, b1.rd_req, b1.wr_bank, b1.wr_addr, b1.wr_data, b1.rd_bank, b1.rd_addr} = '0;
    repeat (2) tick();
    chk("rst_ctl0", {b0.PC_B, b0.WE, b0.SE, b0.mem_sel, b0.busy, b0.wr_ack, b0.rd_ack, b0.acc_err}, 32'h200);
    chk("rst_dat0", {b0.rd_data, b0.mem_data_out}, 0);
    chk("rst_addr0", b0.mem_address, 0);
    chk("rst_ctl1", {b1.PC_B, b1.WE, b1.SE, b1.mem_sel, b1.busy, b1.wr_ack, b1.rd_ack, b1.acc_err}, 32'h200);
    reset = 1'b1;
    tick();
    b0.wr_req = 1; b0.wr_bank = 3'b010; b0.wr_addr = 6'd5; b0.wr_data = 16'hA55A;
    q0.push_back('{wr: 1'b1, err: 1'b0, d: 16'h0});
    tick();
    chk("w_pre", {b0.PC_B, b0.mem_sel, b0.WE}, {1'b0, 3'b010, 1'b0});
    chk("w_addr", b0.mem_address, 5);
    chk("w_data", b0.mem_data_out, 16'hA55A);
    tick();
    chk("w_acc", {b0.PC_B, b0.WE, b0.SE}, 3'b110);
    tick();
    chk("w_ack", b0.wr_ack, 1);
    b0.wr_req = 0;
    tick();
    chk("w_rec", {b0.busy, b0.wr_ack, b0.mem_sel}, {1'b1, 1'b0, 3'b000});
    tick();
    chk("w_idle", b0.busy, 0);
    chk("w_mem", m0[1][5], 16'hA55A);
    b0.rd_req = 1; b0.rd_bank = 3'b001; b0.rd_addr = 6'd3;
    q0.push_back('{wr: 1'b0, err: 1'b0, d: 16'h1234});
    tick();
    chk("r_pre", {b0.PC_B, b0.SE}, 2'b00);
    tick();
    chk("r_acc", {b0.PC_B, b0.WE, b0.SE}, 3'b101);
    tick();
    chk("r_cap", {b0.rd_ack, b0.SE}, 2'b10);
    chk("r_data", b0.rd_data, 16'h1234);
    b0.rd_req = 0;
    idle0();
    b0.rd_req = 1; b0.rd_bank = 3'b011; b0.rd_addr = 6'd0;
    q0.push_back('{wr: 1'b0, err: 1'b1, d: 16'h1234});
    tick();
    chk("rej_cap", {b0.rd_ack, b0.acc_err, b0.PC_B, b0.mem_sel}, 6'b111000);
    chk("rej_data", b0.rd_data, 16'h1234);
    b0.rd_req = 0;
    tick();
    chk("rej_pulse", {b0.rd_ack, b0.acc_err, b0.PC_B}, 3'b001);
    idle0();
    b0.wr_req = 1; b0.wr_bank = 3'b001; b0.wr_addr = 6'd1; b0.wr_data = 16'h1111;
    tick();
    tick();
    chk("mid_we", b0.WE, 1);
    #2 reset = 1'b0;
    #1 chk("mid_rst", {b0.WE, b0.PC_B, b0.mem_sel, b0.wr_ack, b0.busy}, 7'b0100000);
    b0.wr_bank = 3'b100; b0.wr_addr = 6'd7; b0.wr_data = 16'hBEEF;
    b0.rd_req = 1; b0.rd_bank = 3'b100; b0.rd_addr = 6'd7;
    for (int i = 0; i < 2; i++) begin
      q0.push_back('{wr: 1'b1, err: 1'b0, d: 16'h0});
      q0.push_back('{wr: 1'b0, err: 1'b0, d: 16'hBEEF});
    end
    tick();
    chk("rst_hold", {b0.wr_ack, b0.busy, b0.WE}, 0);
    reset = 1'b1;
    n = 0;
    for (int cyc = 1; cyc <= 30 && n < 4; cyc++) begin
      tick();
      if (b0.wr_ack | b0.rd_ack) begin
        c[n] = cyc;
        n++;
      end
    end
    b0.wr_req = 0; b0.rd_req = 0;
    chk("rr_count", n, 4);
    chk("rr_first", c[0], 3);
    for (int i = 1; i < 4; i++) chk("rr_period", c[i] - c[i-1], 5);
    idle0();
    b1.wr_req = 1; b1.wr_bank = 3'b001; b1.wr_addr = 6'd40; b1.wr_data = 16'h0;
    q1.push_back('{wr: 1'b1, err: 1'b1, d: 16'h0});
    tick();
    chk("dep_rej", {b1.wr_ack, b1.acc_err, b1.PC_B, b1.mem_sel}, 6'b111000);
    b1.wr_req = 0;
    idle1();
    b1.wr_req = 1; b1.wr_bank = 3'b010; b1.wr_addr = 6'd9; b1.wr_data = 16'h5A5A;
    q1.push_back('{wr: 1'b1, err: 1'b0, d: 16'h0});
    pl = 0; wh = 0; ack_at = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      if (!b1.PC_B) pl++;
      if (b1.WE) wh++;
      if (b1.wr_ack) begin
        ack_at = cyc;
        b1.wr_req = 0;
      end
    end
    b1.wr_req = 0;
    chk("p_pre_len", pl, 2);
    chk("p_acc_len", wh, 3);
    chk("p_ack_at", ack_at, 6);
    chk("p_idle", b1.busy, 0);
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
